// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator with a pending/active timing shadow applied at frame wrap.
// Optional line interrupt is built when VT_LINE_IRQ_EN is defined.
module video_timing_gen #(
    parameter int unsigned     HW         = 9,
    parameter int unsigned     VW         = 9,
    parameter logic [HW-1:0]   HTOTAL_DEF = 383,
    parameter logic [HW-1:0]   HBS_DEF    = 255,
    parameter logic [HW-1:0]   HBE_DEF    = 383,
    parameter logic [HW-1:0]   HSS_DEF    = 296,
    parameter logic [HW-1:0]   HSE_DEF    = 321,
    parameter logic [VW-1:0]   VTOTAL_DEF = 262,
    parameter logic [VW-1:0]   VBS_DEF    = 240,
    parameter logic [VW-1:0]   VBE_DEF    = 16,
    parameter logic [VW-1:0]   VSS_DEF    = 253,
    parameter logic [VW-1:0]   VSE_DEF    = 261,
    parameter bit              HS_POL     = 1'b1,
    parameter bit              VS_POL     = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          cfg_wr,
    input  logic [HW-1:0] cfg_htotal,
    input  logic [HW-1:0] cfg_hbs,
    input  logic [HW-1:0] cfg_hbe,
    input  logic [HW-1:0] cfg_hss,
    input  logic [HW-1:0] cfg_hse,
    input  logic [VW-1:0] cfg_vtotal,
    input  logic [VW-1:0] cfg_vbs,
    input  logic [VW-1:0] cfg_vbe,
    input  logic [VW-1:0] cfg_vss,
    input  logic [VW-1:0] cfg_vse,
`ifdef VT_LINE_IRQ_EN
    input  logic [VW-1:0] irq_line,
    input  logic          irq_ack,
    output logic          irq,
`endif
    output logic          cfg_pending,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          hbl,
    output logic          vbl,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    typedef struct packed {
        logic [HW-1:0] htotal;
        logic [HW-1:0] hbs;
        logic [HW-1:0] hbe;
        logic [HW-1:0] hss;
        logic [HW-1:0] hse;
        logic [VW-1:0] vtotal;
        logic [VW-1:0] vbs;
        logic [VW-1:0] vbe;
        logic [VW-1:0] vss;
        logic [VW-1:0] vse;
    } timing_t;

    localparam timing_t TIMING_DEF = '{HTOTAL_DEF, HBS_DEF, HBE_DEF, HSS_DEF, HSE_DEF,
                                       VTOTAL_DEF, VBS_DEF, VBE_DEF, VSS_DEF, VSE_DEF};

    timing_t       act_q, act_d, pend_q, pend_d, cfg_in;
    logic          pending_q, pending_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d, vc_next;
    logic          hbl_q, hbl_d, vbl_q, vbl_d, hs_q, hs_d, vs_q, vs_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic          h_wrap, f_wrap;

    // Start has priority over end, so equal values latch the flag on.
    function automatic logic flag_next(input logic cur, input logic set, input logic clr);
        return set ? 1'b1 : (clr ? 1'b0 : cur);
    endfunction

    always_comb begin
        cfg_in  = '{cfg_htotal, cfg_hbs, cfg_hbe, cfg_hss, cfg_hse,
                    cfg_vtotal, cfg_vbs, cfg_vbe, cfg_vss, cfg_vse};
        h_wrap  = (hc_q == act_q.htotal);
        f_wrap  = h_wrap && (vc_q == act_q.vtotal);
        vc_next = f_wrap ? '0 : vc_q + 1'b1;

        act_d     = act_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        hc_d      = hc_q;
        vc_d      = vc_q;
        hbl_d     = hbl_q;
        vbl_d     = vbl_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        ls_d      = 1'b0;
        fs_d      = 1'b0;

        if (ce_pix) begin
            hc_d  = h_wrap ? '0 : hc_q + 1'b1;
            if (h_wrap) vc_d = vc_next;
            hbl_d = flag_next(hbl_q, hc_q == act_q.hbs, hc_q == act_q.hbe);
            hs_d  = flag_next(hs_q,  hc_q == act_q.hss, hc_q == act_q.hse);
            vbl_d = flag_next(vbl_q, vc_q == act_q.vbs, vc_q == act_q.vbe);
            vs_d  = flag_next(vs_q,  vc_q == act_q.vss, vc_q == act_q.vse);
            ls_d  = h_wrap;
            fs_d  = f_wrap;
            if (f_wrap && pending_q) begin
                act_d     = pend_q;
                pending_d = 1'b0;
            end
        end

        // A write on the apply clock is captured after the old pending set was consumed.
        if (cfg_wr) begin
            pend_d    = cfg_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            act_q     <= TIMING_DEF;
            pend_q    <= TIMING_DEF;
            pending_q <= 1'b0;
            hc_q      <= '0;
            vc_q      <= '0;
            hbl_q     <= 1'b0;
            vbl_q     <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            act_q     <= act_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hbl_q     <= hbl_d;
            vbl_q     <= vbl_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
        end
    end

`ifdef VT_LINE_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_ack) irq_d = 1'b0;
        if (ce_pix && h_wrap && (vc_next == irq_line)) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    assign cfg_pending = pending_q;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hbl         = hbl_q;
    assign vbl         = vbl_q;
    assign hsync       = HS_POL ? hs_q : ~hs_q;
    assign vsync       = VS_POL ? vs_q : ~vs_q;
    assign de          = ~hbl_q & ~vbl_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: instance 0 runs the full default raster, instance 1 a small
// low-polarity raster used for shadow, collision, gating and out-of-range timing cases.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [2];
    logic       ce    [2];
    logic       wr    [2];
    logic [8:0] ch    [2][5];
    logic [8:0] cv    [2][5];

    logic       pend_o [2];
    logic [8:0] hc_o   [2];
    logic [8:0] vc_o   [2];
    logic       hbl_o  [2];
    logic       vbl_o  [2];
    logic       hs_o   [2];
    logic       vs_o   [2];
    logic       de_o   [2];
    logic       ls_o   [2];
    logic       fs_o   [2];
`ifdef VT_LINE_IRQ_EN
    logic [8:0] il     [2];
    logic       ack    [2];
    logic       irq_o  [2];
`endif

    video_timing_gen dut_a (
        .clk(clk), .reset(rst_n[0]), .ce_pix(ce[0]), .cfg_wr(wr[0]),
        .cfg_htotal(ch[0][0]), .cfg_hbs(ch[0][1]), .cfg_hbe(ch[0][2]), .cfg_hss(ch[0][3]), .cfg_hse(ch[0][4]),
        .cfg_vtotal(cv[0][0]), .cfg_vbs(cv[0][1]), .cfg_vbe(cv[0][2]), .cfg_vss(cv[0][3]), .cfg_vse(cv[0][4]),
`ifdef VT_LINE_IRQ_EN
        .irq_line(il[0]), .irq_ack(ack[0]), .irq(irq_o[0]),
`endif
        .cfg_pending(pend_o[0]), .hc(hc_o[0]), .vc(vc_o[0]), .hbl(hbl_o[0]), .vbl(vbl_o[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0])
    );

    video_timing_gen #(
        .HTOTAL_DEF(9'd23), .HBS_DEF(9'd15), .HBE_DEF(9'd23), .HSS_DEF(9'd17), .HSE_DEF(9'd19),
        .VTOTAL_DEF(9'd12), .VBS_DEF(9'd9),  .VBE_DEF(9'd1),  .VSS_DEF(9'd10), .VSE_DEF(9'd11),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst_n[1]), .ce_pix(ce[1]), .cfg_wr(wr[1]),
        .cfg_htotal(ch[1][0]), .cfg_hbs(ch[1][1]), .cfg_hbe(ch[1][2]), .cfg_hss(ch[1][3]), .cfg_hse(ch[1][4]),
        .cfg_vtotal(cv[1][0]), .cfg_vbs(cv[1][1]), .cfg_vbe(cv[1][2]), .cfg_vss(cv[1][3]), .cfg_vse(cv[1][4]),
`ifdef VT_LINE_IRQ_EN
        .irq_line(il[1]), .irq_ack(ack[1]), .irq(irq_o[1]),
`endif
        .cfg_pending(pend_o[1]), .hc(hc_o[1]), .vc(vc_o[1]), .hbl(hbl_o[1]), .vbl(vbl_o[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1])
    );

    int total = 0;
    int bad   = 0;

    // Timing set order: htotal hbs hbe hss hse vtotal vbs vbe vss vse.
    int def   [2][10] = '{'{383, 255, 383, 296, 321, 262, 240, 16, 253, 261},
                          '{23, 15, 23, 17, 19, 12, 9, 1, 10, 11}};
    int pol_h [2] = '{1, 0};
    int pol_v [2] = '{1, 0};

    int mh [2], mv [2];
    int act [2][10], pnd [2][10];
    bit mhbl [2], mvbl [2], mhs [2], mvs [2], mls [2], mfs [2], mp [2], mirq [2], valid [2];

    task automatic chk(input string nm, input int k, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            if (bad <= 20) $display("FAIL %s[%0d] got=%0d exp=%0d at %0t", nm, k, a, e, $time);
        end
    endtask

    function automatic bit upd(input bit cur, input int c, input int s, input int e);
        return (c == s) ? 1'b1 : ((c == e) ? 1'b0 : cur);
    endfunction

    // Raster position is treated as a linear pixel index within the frame.
    task automatic step(input int k);
        int nw [10];
        int hn, vn, p;
        bit lw, fw, set;
        for (int i = 0; i < 5; i++) begin
            nw[i]     = int'(ch[k][i]);
            nw[i + 5] = int'(cv[k][i]);
        end
        if (!rst_n[k]) begin
            mh[k] = 0; mv[k] = 0;
            mhbl[k] = 0; mvbl[k] = 0; mhs[k] = 0; mvs[k] = 0;
            mls[k] = 0; mfs[k] = 0; mp[k] = 0; mirq[k] = 0;
            for (int i = 0; i < 10; i++) act[k][i] = def[k][i];
            valid[k] = 1;
            return;
        end
        set = 0;
        mls[k] = 0;
        mfs[k] = 0;
        if (ce[k]) begin
            hn = act[k][0] + 1;
            vn = act[k][5] + 1;
            p  = mv[k] * hn + mh[k];
            lw = (mh[k] == hn - 1);
            fw = (p == hn * vn - 1);
            mhbl[k] = upd(mhbl[k], mh[k], act[k][1], act[k][2]);
            mhs[k]  = upd(mhs[k],  mh[k], act[k][3], act[k][4]);
            mvbl[k] = upd(mvbl[k], mv[k], act[k][6], act[k][7]);
            mvs[k]  = upd(mvs[k],  mv[k], act[k][8], act[k][9]);
            p = (p + 1) % (hn * vn);
            mh[k] = p % hn;
            mv[k] = p / hn;
            mls[k] = lw;
            mfs[k] = fw;
`ifdef VT_LINE_IRQ_EN
            set = lw && (mv[k] == int'(il[k]));
`endif
            if (fw && mp[k]) begin
                for (int i = 0; i < 10; i++) act[k][i] = pnd[k][i];
                mp[k] = 0;
            end
        end
`ifdef VT_LINE_IRQ_EN
        if (set) mirq[k] = 1;
        else if (ack[k]) mirq[k] = 0;
`endif
        if (wr[k]) begin
            for (int i = 0; i < 10; i++) pnd[k][i] = nw[i];
            mp[k] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (valid[k]) begin
                chk("hc", k, int'(hc_o[k]), mh[k]);
                chk("vc", k, int'(vc_o[k]), mv[k]);
                chk("hbl", k, int'(hbl_o[k]), int'(mhbl[k]));
                chk("vbl", k, int'(vbl_o[k]), int'(mvbl[k]));
                chk("hsync", k, int'(hs_o[k]), pol_h[k] != 0 ? int'(mhs[k]) : int'(!mhs[k]));
                chk("vsync", k, int'(vs_o[k]), pol_v[k] != 0 ? int'(mvs[k]) : int'(!mvs[k]));
                chk("de", k, int'(de_o[k]), int'(!mhbl[k] && !mvbl[k]));
                chk("line_start", k, int'(ls_o[k]), int'(mls[k]));
                chk("frame_start", k, int'(fs_o[k]), int'(mfs[k]));
                chk("cfg_pending", k, int'(pend_o[k]), int'(mp[k]));
`ifdef VT_LINE_IRQ_EN
                chk("irq", k, int'(irq_o[k]), int'(mirq[k]));
`endif
            end
        end
    end

    task automatic load(input int k, input int v [10]);
        for (int i = 0; i < 5; i++) begin
            ch[k][i] = 9'(v[i]);
            cv[k][i] = 9'(v[i + 5]);
        end
    endtask

    task automatic wait_fs(input int k, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!fs_o[k] && n < 5000);
        if (!fs_o[k]) chk("frame_start_timeout", k, 0, 1);
    endtask

    task automatic branch_a();
        int s_alt [10] = '{100, 50, 60, 70, 80, 120, 100, 5, 110, 115};
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hc", 0, int'(hc_o[0]), 0);
        chk("rst_vc", 0, int'(vc_o[0]), 0);
        chk("rst_de", 0, int'(de_o[0]), 1);
        chk("rst_hsync", 0, int'(hs_o[0]), 0);
        chk("rst_vsync", 0, int'(vs_o[0]), 0);
        chk("rst_pending", 0, int'(pend_o[0]), 0);
        @(negedge clk) rst_n[0] = 1'b1;
        repeat (255) @(posedge clk); #1;
        chk("hc255", 0, int'(hc_o[0]), 255);
        chk("hbl_at255", 0, int'(hbl_o[0]), 0);
        @(posedge clk); #1;
        chk("hbl_at256", 0, int'(hbl_o[0]), 1);
        repeat (40) @(posedge clk); #1;
        chk("hsync_at296", 0, int'(hs_o[0]), 0);
        @(posedge clk); #1;
        chk("hsync_at297", 0, int'(hs_o[0]), 1);
        repeat (24) @(posedge clk); #1;
        chk("hsync_at321", 0, int'(hs_o[0]), 1);
        @(posedge clk); #1;
        chk("hsync_at322", 0, int'(hs_o[0]), 0);
        repeat (61) @(posedge clk); #1;
        chk("hc383", 0, int'(hc_o[0]), 383);
        chk("hbl_at383", 0, int'(hbl_o[0]), 1);
        @(posedge clk); #1;
        chk("wrap_hc", 0, int'(hc_o[0]), 0);
        chk("wrap_vc", 0, int'(vc_o[0]), 1);
        chk("wrap_ls", 0, int'(ls_o[0]), 1);
        chk("wrap_hbl", 0, int'(hbl_o[0]), 0);
        @(negedge clk);
        load(0, s_alt);
        wr[0] = 1'b1;
        @(negedge clk) wr[0] = 1'b0;
        repeat (19015) @(posedge clk); #1;
        chk("mid_hc", 0, int'(hc_o[0]), 200);
        chk("mid_vc", 0, int'(vc_o[0]), 50);
        chk("mid_pending", 0, int'(pend_o[0]), 1);
        @(negedge clk) rst_n[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst2_hc", 0, int'(hc_o[0]), 0);
        chk("rst2_vc", 0, int'(vc_o[0]), 0);
        chk("rst2_pending", 0, int'(pend_o[0]), 0);
        @(negedge clk) rst_n[0] = 1'b1;
        repeat (383) @(posedge clk); #1;
        chk("rst2_hc383", 0, int'(hc_o[0]), 383);
        chk("rst2_hbl", 0, int'(hbl_o[0]), 1);
        @(posedge clk); #1;
        chk("rst2_wrap_vc", 0, int'(vc_o[0]), 1);
    endtask

    task automatic branch_b();
        int s_v17 [10] = '{23, 15, 23, 17, 19, 17, 9, 1, 10, 11};
        int s_h30 [10] = '{30, 15, 23, 17, 19, 17, 9, 1, 10, 11};
        int s_h35 [10] = '{35, 15, 23, 17, 19, 17, 9, 1, 10, 11};
        int s_x   [10] = '{27, 20, 40, 22, 24, 9, 7, 1, 8, 8};
        int s_y   [10] = '{23, 15, 23, 17, 19, 12, 9, 1, 10, 11};
        int n;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hsync_lowpol", 1, int'(hs_o[1]), 1);
        chk("rst_vsync_lowpol", 1, int'(vs_o[1]), 1);
        @(negedge clk) rst_n[1] = 1'b1;
        wait_fs(1, n);
        chk("period_default", 1, n, 312);
        repeat (120) @(negedge clk);
        load(1, s_v17);
        wr[1] = 1'b1;
        @(negedge clk) wr[1] = 1'b0;
        @(posedge clk); #1;
        chk("pending_set", 1, int'(pend_o[1]), 1);
        wait_fs(1, n);
        chk("old_frame_rest", 1, n, 191);
        chk("pending_applied", 1, int'(pend_o[1]), 0);
        wait_fs(1, n);
        chk("period_v17", 1, n, 432);
        repeat (50) @(negedge clk);
        load(1, s_h30);
        wr[1] = 1'b1;
        @(negedge clk) wr[1] = 1'b0;
        repeat (50) @(negedge clk);
        load(1, s_h35);
        wr[1] = 1'b1;
        @(negedge clk) wr[1] = 1'b0;
        wait_fs(1, n);
        chk("collide_rest", 1, n, 331);
        wait_fs(1, n);
        chk("period_h35", 1, n, 648);
        repeat (100) @(negedge clk);
        load(1, s_x);
        wr[1] = 1'b1;
        @(negedge clk) wr[1] = 1'b0;
        repeat (547) @(negedge clk);
        load(1, s_y);
        wr[1] = 1'b1;
        @(posedge clk); #1;
        chk("apply_clk_fs", 1, int'(fs_o[1]), 1);
        chk("apply_clk_pending", 1, int'(pend_o[1]), 1);
        @(negedge clk) wr[1] = 1'b0;
        wait_fs(1, n);
        chk("period_x", 1, n, 280);
        chk("pending_y_applied", 1, int'(pend_o[1]), 0);
        wait_fs(1, n);
        chk("period_y", 1, n, 312);
`ifdef VT_LINE_IRQ_EN
        chk("irq_on_wrap", 1, int'(irq_o[1]), 1);
`endif
        for (int i = 0; i < 200; i++) begin
            @(negedge clk) ce[1] = (i % 4 == 0);
        end
        chk("gated_hc", 1, int'(hc_o[1]), 2);
        chk("gated_vc", 1, int'(vc_o[1]), 2);
        @(negedge clk) ce[1] = 1'b1;
`ifdef VT_LINE_IRQ_EN
        ack[1] = 1'b1;
        @(negedge clk) ack[1] = 1'b0;
        chk("irq_acked", 1, int'(irq_o[1]), 0);
`endif
        repeat (40) @(posedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            ce[k]    = 1'b1;
            wr[k]    = 1'b0;
            for (int i = 0; i < 5; i++) begin
                ch[k][i] = 9'(def[k][i]);
                cv[k][i] = 9'(def[k][i + 5]);
            end
`ifdef VT_LINE_IRQ_EN
            ack[k] = 1'b0;
`endif
        end
`ifdef VT_LINE_IRQ_EN
        il[0] = 9'd3;
        il[1] = 9'd0;
`endif
        fork
            branch_a();
            branch_b();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
